cacheline_burst_ctrl: RTL and testbench
=======================================

CACHELINE_BURST_CTRL -- requirements
Module: cacheline_burst_ctrl

Interface
REQ-001 SHALL have parameter LINE_W, default 256, meaning cache line width in bits.
REQ-002 SHALL have parameter WORD_W, default 32, meaning memory beat width in bits; BEATS = LINE_W/WORD_W = 8.
REQ-003 SHALL have parameter ADDR_W, default 32, meaning byte address width.
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have port line_read  in  1  cache requests line fill; held until line_resp.
REQ-007 SHALL have port line_write  in  1  cache requests line writeback; held until line_resp.
REQ-008 SHALL have port line_addr  in  ADDR_W  line byte address; bits [4:0] ignored.
REQ-009 SHALL have port line_wdata  in  LINE_W  line to write back.
REQ-010 SHALL have port line_rdata  out  LINE_W  assembled fill line.
REQ-011 SHALL have port line_resp  out  1  one-cycle completion pulse.
REQ-012 SHALL have port busy  out  1  high in any state other than IDLE.
REQ-013 SHALL have port mem_read  out  1  per-beat memory read strobe.
REQ-014 SHALL have port mem_write  out  1  per-beat memory write strobe.
REQ-015 SHALL have port mem_addr  out  ADDR_W  current beat byte address.
REQ-016 SHALL have port mem_wdata  out  WORD_W  current beat write data.
REQ-017 SHALL have port mem_rdata  in  WORD_W  beat read data, valid with mem_resp.
REQ-018 SHALL have port mem_resp  in  1  memory completes current beat this cycle.

Function
REQ-019 SHALL implement states IDLE, RD_BURST, WR_BURST, DONE with a 3-bit beat counter.
REQ-020 In IDLE, line_write=1 SHALL latch line_addr (bits [4:0] zeroed) and line_wdata and go to WR_BURST; write wins if line_read is also high.
REQ-021 In IDLE, line_read=1 with line_write=0 SHALL latch the aligned address and go to RD_BURST.
REQ-022 On entry to either burst state the beat counter SHALL be 0.
REQ-023 mem_addr SHALL equal latched base + 4*beat in burst states, and the latched base otherwise.
REQ-024 In RD_BURST, mem_read SHALL be 1 and mem_write 0 every cycle; in WR_BURST, mem_write SHALL be 1 and mem_read 0 every cycle.
REQ-025 mem_wdata SHALL equal latched line bits [32*beat+31 : 32*beat] in WR_BURST, and 0 otherwise.
REQ-026 On a RD_BURST cycle with mem_resp=1, mem_rdata SHALL be stored into line_rdata bits [32*beat+31 : 32*beat] and the beat counter SHALL increment.
REQ-027 On a WR_BURST cycle with mem_resp=1, the beat counter SHALL increment.
REQ-028 A cycle with mem_resp=0 SHALL hold the beat counter, mem_addr, and the strobes; there is no timeout.
REQ-029 mem_resp on beat 7 SHALL move the FSM to DONE and wrap the counter to 0.
REQ-030 In DONE, line_resp SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-031 line_rdata SHALL hold its value from DONE until the next read burst writes a beat; write bursts SHALL NOT modify it.
REQ-032 A request still asserted in IDLE after DONE SHALL be accepted as a new request; the cache drops it the cycle after line_resp.
REQ-033 mem_resp in IDLE or DONE SHALL be ignored.
REQ-034 line_read, line_write, line_addr and line_wdata changes during a burst SHALL be ignored.
REQ-035 Latency SHALL be 1 (accept) + 8 beat cycles + 1 (DONE): with zero-wait memory and the request at edge 0, line_resp is high in cycle 9.

Reset
REQ-036 rst_n=0 SHALL immediately force IDLE, beat counter 0, latched address/data 0, line_rdata 0, line_resp 0, busy 0, mem_read 0, mem_write 0, mem_addr 0, mem_wdata 0.
REQ-037 Reset asserted mid-burst SHALL abandon the burst with no line_resp; the first request after rst_n rises SHALL start at beat 0.

Verification
REQ-038 Read fill, zero-wait: line_read, addr 0x0000_1234, mem_rdata = 0x1111_1111*(beat+1) -> mem_addr 0x1220..0x123C, line_resp in cycle 9, line_rdata = {0x8888_8888,...,0x1111_1111}.
REQ-039 Writeback: line_write, addr 0x40, line_wdata word i = 0xA000_0000+i -> beat i drives mem_addr 0x40+4i with mem_wdata 0xA000_000i, then one line_resp.
REQ-040 Wait states: mem_resp low 3 cycles before each beat -> strobes and address held, line_resp in cycle 33.
REQ-041 Simultaneous line_read and line_write -> WR_BURST first (mem_write=1), then after line_resp a still-held line_read -> RD_BURST.
REQ-042 rst_n low during beat 4 of a read -> all outputs 0 asynchronously, no line_resp; next read completes normally from beat 0.

Source files
------------

// File: rtl/cacheline_burst_ctrl.sv
// Cache-line burst controller: turns one line fill or writeback request into
// a sequence of word-wide memory beats, assembling fill data into line_rdata.
module cacheline_burst_ctrl #(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned WORD_W = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              line_read,
  input  logic              line_write,
  input  logic [ADDR_W-1:0] line_addr,
  input  logic [LINE_W-1:0] line_wdata,
  output logic [LINE_W-1:0] line_rdata,
  output logic              line_resp,
  output logic              busy,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  localparam int unsigned BEATS   = LINE_W / WORD_W;
  localparam int unsigned BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned OFS_W   = $clog2(LINE_W / 8);
  localparam int unsigned STEP_SH = $clog2(WORD_W / 8);
  localparam int unsigned LOFS_W  = $clog2(LINE_W);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [BEAT_W-1:0]   beat, beat_nxt;
  logic [ADDR_W-1:0]   base, base_nxt;
  logic [LINE_W-1:0]   wline, wline_nxt;
  logic [LINE_W-1:0]   rline, rline_nxt;
  logic [ADDR_W-1:0]   aligned_addr;
  logic [LOFS_W-1:0]   bit_ofs;
  logic                last_beat;
  logic                addr_ofs_unused;

  // Sub-line offset bits of the request address play no part in a line burst.
  assign addr_ofs_unused = ^line_addr[OFS_W-1:0];
  assign aligned_addr    = {line_addr[ADDR_W-1:OFS_W], OFS_W'(0)};
  assign bit_ofs         = LOFS_W'(beat) * LOFS_W'(WORD_W);
  assign last_beat       = (beat == BEAT_W'(BEATS - 1));

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      beat  <= '0;
      base  <= '0;
      wline <= '0;
      rline <= '0;
    end else begin
      state <= state_nxt;
      beat  <= beat_nxt;
      base  <= base_nxt;
      wline <= wline_nxt;
      rline <= rline_nxt;
    end
  end

  // Next-state: accept in IDLE (write has priority), advance a beat on mem_resp
  always_comb begin
    state_nxt = state;
    beat_nxt  = beat;
    base_nxt  = base;
    wline_nxt = wline;
    rline_nxt = rline;
    case (state)
      IDLE: begin
        if (line_write) begin
          base_nxt  = aligned_addr;
          wline_nxt = line_wdata;
          beat_nxt  = '0;
          state_nxt = WR_BURST;
        end else if (line_read) begin
          base_nxt  = aligned_addr;
          beat_nxt  = '0;
          state_nxt = RD_BURST;
        end
      end
      RD_BURST: begin
        if (mem_resp) begin
          rline_nxt[bit_ofs +: WORD_W] = mem_rdata;
          if (last_beat) begin
            beat_nxt  = '0;
            state_nxt = DONE;
          end else begin
            beat_nxt = beat + BEAT_W'(1);
          end
        end
      end
      WR_BURST: begin
        if (mem_resp) begin
          if (last_beat) begin
            beat_nxt  = '0;
            state_nxt = DONE;
          end else begin
            beat_nxt = beat + BEAT_W'(1);
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        beat_nxt  = '0;
      end
    endcase
  end

  // Outputs decode straight from registered state, so reset clears them at once
  always_comb begin
    line_rdata = rline;
    line_resp  = (state == DONE);
    busy       = (state != IDLE);
    mem_read   = (state == RD_BURST);
    mem_write  = (state == WR_BURST);
    mem_addr   = base;
    mem_wdata  = '0;
    if (state == RD_BURST || state == WR_BURST) begin
      mem_addr = base + (ADDR_W'(beat) << STEP_SH);
    end
    if (state == WR_BURST) begin
      mem_wdata = wline[bit_ofs +: WORD_W];
    end
  end

endmodule

// File: tb/tb_cacheline_burst_ctrl.sv
// Directed bench for cacheline_burst_ctrl: fill, writeback, wait states,
// read/write collision, stray mem_resp and reset mid-burst.
module tb_cacheline_burst_ctrl;

  logic         clk;
  logic         rst_n;
  logic         line_read;
  logic         line_write;
  logic [31:0]  line_addr;
  logic [255:0] line_wdata;
  logic [255:0] line_rdata;
  logic         line_resp;
  logic         busy;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata;
  logic         mem_resp;

  int n_checks;
  int n_errors;
  int wait_cfg;
  int wcnt;
  logic stray;
  logic [255:0] exp_line;
  logic [255:0] wline;
  int cyc;

  cacheline_burst_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .line_read  (line_read),
    .line_write (line_write),
    .line_addr  (line_addr),
    .line_wdata (line_wdata),
    .line_rdata (line_rdata),
    .line_resp  (line_resp),
    .busy       (busy),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_resp   (mem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory responder: wait_cfg idle cycles before each beat's response
  initial begin
    mem_resp  = 1'b0;
    mem_rdata = '0;
    wcnt      = 0;
    forever begin
      @(negedge clk);
      if (mem_read || mem_write) begin
        if (wcnt >= wait_cfg) begin
          mem_resp  = 1'b1;
          mem_rdata = 32'(32'h1111_1111 * (int'(mem_addr[4:2]) + 1));
          wcnt      = 0;
        end else begin
          mem_resp = 1'b0;
          wcnt     = wcnt + 1;
        end
      end else begin
        mem_resp  = stray;
        mem_rdata = 32'hDEAD_BEEF;
        wcnt      = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_resp(input int max_cyc, output int n);
    n = 0;
    while (n < max_cyc) begin
      @(negedge clk);
      n++;
      if (line_resp) break;
    end
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    wait_cfg   = 0;
    stray      = 1'b0;
    rst_n      = 1'b0;
    line_read  = 1'b0;
    line_write = 1'b0;
    line_addr  = '0;
    line_wdata = '0;
    for (int i = 0; i < 8; i++) begin
      exp_line[32*i +: 32] = 32'(32'h1111_1111 * (i + 1));
      wline[32*i +: 32]    = 32'(32'hA000_0000 + i);
    end

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_line_rdata", line_rdata, '0);
    check("rst_line_resp", 256'(line_resp), '0);
    check("rst_busy", 256'(busy), '0);
    check("rst_mem_read", 256'(mem_read), '0);
    check("rst_mem_write", 256'(mem_write), '0);
    check("rst_mem_addr", 256'(mem_addr), '0);
    check("rst_mem_wdata", 256'(mem_wdata), '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Zero-wait read fill at 0x1234
    line_read = 1'b1;
    line_addr = 32'h0000_1234;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check($sformatf("rd_addr_b%0d", k - 1), 256'(mem_addr), 256'(32'h1220 + 4 * (k - 1)));
      check($sformatf("rd_strobe_b%0d", k - 1), 256'({busy, mem_read, mem_write, line_resp}), 256'(4'b1100));
    end
    @(negedge clk);
    check("rd_resp_cycle9", 256'(line_resp), 256'(1));
    check("rd_line", line_rdata, exp_line);
    line_read = 1'b0;
    @(negedge clk);
    check("rd_idle_busy_resp", 256'({busy, line_resp}), '0);
    check("rd_idle_addr", 256'(mem_addr), 256'(32'h1220));
    check("rd_line_held", line_rdata, exp_line);

    // Stray mem_resp while idle is ignored
    stray = 1'b1;
    repeat (3) @(negedge clk);
    check("stray_busy", 256'(busy), '0);
    check("stray_line", line_rdata, exp_line);
    stray = 1'b0;

    // Writeback at 0x40
    line_write = 1'b1;
    line_addr  = 32'h0000_0040;
    line_wdata = wline;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check($sformatf("wr_addr_b%0d", k - 1), 256'(mem_addr), 256'(32'h40 + 4 * (k - 1)));
      check($sformatf("wr_data_b%0d", k - 1), 256'(mem_wdata), 256'(32'hA000_0000 + k - 1));
      check($sformatf("wr_strobe_b%0d", k - 1), 256'({mem_read, mem_write}), 256'(2'b01));
    end
    @(negedge clk);
    check("wr_resp_cycle9", 256'(line_resp), 256'(1));
    check("wr_line_untouched", line_rdata, exp_line);
    line_write = 1'b0;
    @(negedge clk);
    check("wr_idle_resp_wdata", 256'({line_resp, mem_wdata}), '0);

    // Wait states: three idle cycles before every beat
    wait_cfg  = 3;
    line_read = 1'b1;
    line_addr = 32'h0000_1234;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      check($sformatf("ws_addr_c%0d", c), 256'(mem_addr), 256'(32'h1220 + 4 * ((c - 1) / 4)));
      check($sformatf("ws_strobe_c%0d", c), 256'({mem_read, mem_write, line_resp}), 256'(3'b100));
    end
    @(negedge clk);
    check("ws_resp_cycle33", 256'(line_resp), 256'(1));
    check("ws_line", line_rdata, exp_line);
    line_read = 1'b0;
    wait_cfg  = 0;
    @(negedge clk);

    // Simultaneous read and write: write first, held read follows
    line_read  = 1'b1;
    line_write = 1'b1;
    line_addr  = 32'h0000_0080;
    @(negedge clk);
    check("col_write_first", 256'({mem_read, mem_write}), 256'(2'b01));
    check("col_wr_addr", 256'(mem_addr), 256'(32'h80));
    line_write = 1'b0;
    wait_resp(20, cyc);
    check("col_wr_latency", 256'(cyc), 256'(8));
    @(negedge clk);
    check("col_idle_between", 256'(busy), '0);
    @(negedge clk);
    check("col_read_second", 256'({mem_read, mem_write}), 256'(2'b10));
    check("col_rd_addr", 256'(mem_addr), 256'(32'h80));
    line_read = 1'b0;
    line_addr = 32'h0000_FFF0;
    @(negedge clk);
    check("col_addr_change_ignored", 256'(mem_addr), 256'(32'h84));
    wait_resp(20, cyc);
    check("col_rd_latency", 256'(cyc), 256'(7));
    check("col_rd_line", line_rdata, exp_line);
    @(negedge clk);

    // Reset during beat 4 of a read
    line_read = 1'b1;
    line_addr = 32'h0000_1234;
    repeat (5) @(negedge clk);
    check("mid_beat4_addr", 256'(mem_addr), 256'(32'h1230));
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_outputs", 256'({busy, line_resp, mem_read, mem_write, mem_addr, mem_wdata}), '0);
    check("mid_rst_line", line_rdata, '0);
    line_read = 1'b0;
    @(negedge clk);
    check("mid_rst_no_resp", 256'(line_resp), '0);
    rst_n = 1'b1;
    @(negedge clk);
    line_read = 1'b1;
    line_addr = 32'h0000_0200;
    @(negedge clk);
    check("post_rst_beat0", 256'(mem_addr), 256'(32'h200));
    wait_resp(20, cyc);
    check("post_rst_latency", 256'(cyc), 256'(8));
    check("post_rst_line", line_rdata, exp_line);
    line_read = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
